// File: rtl/mac9_preact_q15.sv
// Serial 3x3 multiply-accumulate producing one rounded, saturated Q1.15 pre-activation
// per 9-beat group (bias + sum of x*w). The result is held until the consumer accepts it.
module mac9_preact_q15 #(
  parameter int DATA_W = 16,
  parameter int N_TAPS = 9,
  parameter int ACC_W  = 36
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bias,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_x,
  input  logic [DATA_W-1:0] s_w,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sat
);

  localparam int CNT_W = $clog2(N_TAPS + 1);
  localparam int FRAC  = DATA_W - 1;
  localparam logic signed [ACC_W-1:0] RND   = ACC_W'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W-1:0] R_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] R_MIN = -ACC_W'(2 ** (DATA_W - 1));

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t                   state_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic                     s_ready_reg;
  logic                     m_valid_reg;
  logic [DATA_W-1:0]        m_data_reg;
  logic                     m_sat_reg;

  logic signed [2*DATA_W-1:0] x_ext, w_ext, prod;
  logic signed [ACC_W-1:0]    prod_ext, bias_ext, acc_base, acc_sum, acc_rnd, r_full;
  logic [DATA_W-1:0]          sat_data;
  logic                       sat_flag;
  logic                       accept, last_beat;

  // Full-precision Q2.30 product; (-1)*(-1) fits exactly in 2*DATA_W bits.
  assign x_ext    = {{DATA_W{s_x[DATA_W-1]}}, s_x};
  assign w_ext    = {{DATA_W{s_w[DATA_W-1]}}, s_w};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W-FRAC){bias[DATA_W-1]}}, bias, {FRAC{1'b0}}};

  // The first beat seeds the accumulator with the aligned bias instead of the old sum.
  assign acc_base = (state_reg == IDLE) ? bias_ext : acc_reg;
  assign acc_sum  = acc_base + prod_ext;
  assign acc_rnd  = acc_sum + RND;
  assign r_full   = acc_rnd >>> FRAC;

  always_comb begin
    sat_data = r_full[DATA_W-1:0];
    sat_flag = 1'b0;
    if (r_full > R_MAX) begin
      sat_data = {1'b0, {(DATA_W-1){1'b1}}};
      sat_flag = 1'b1;
    end else if (r_full < R_MIN) begin
      sat_data = {1'b1, {(DATA_W-1){1'b0}}};
      sat_flag = 1'b1;
    end
  end

  assign accept    = s_valid && s_ready_reg;
  assign last_beat = (cnt_reg == CNT_W'(N_TAPS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      s_ready_reg <= 1'b1;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_sat_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, ACC: begin
          if (accept) begin
            acc_reg <= acc_sum;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (last_beat) begin
              m_valid_reg <= 1'b1;
              m_data_reg  <= sat_data;
              m_sat_reg   <= sat_flag;
              s_ready_reg <= 1'b0;
              state_reg   <= OUT;
            end else begin
              state_reg <= ACC;
            end
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid_reg <= 1'b0;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            s_ready_reg <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign s_ready = s_ready_reg;
  assign m_valid = m_valid_reg;
  assign m_data  = m_data_reg;
  assign m_sat   = m_sat_reg;

endmodule
